rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
Round-robin arbiter that shares one resource among 4 requesters.
- Keeps a registered 2-bit winner index.
- Drives a one-hot grant bus through a 2-to-4 decoder.
- Bounds how long one requester can hold the resource while others wait.
- Sits between 4 client blocks and a single shared datapath or bus.

Parameters:
HOLD_MAX, 4, maximum consecutive grant cycles for one requester while another request is pending. Legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request lines. req[i]=1 means requester i wants the resource; it stays high for as long as it needs it.
grant  output  4  one-hot grant, or 4'b0000 when idle
grant_idx  output  2  encoded index of the current winner (registered)
grant_valid  output  1  high while any grant is active (registered)

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.
- All decisions use the req value sampled at the rising edge.

Reset (rst=1 at an edge):
- state=IDLE, grant_valid=0, grant_idx=2'd0, grant=4'b0000.
- last=2'd3, so requester 0 has top priority after reset.
- hold_cnt=0.
- If rst is asserted mid-grant, grant goes to 0000 after that edge. No handoff occurs.

grant output:
- grant = grant_valid ? decode(grant_idx) : 4'b0000.
- Combinational from registered signals only, so always one-hot or zero.

Winner search:
- Search upward from (start+1) mod 4, wrapping.
- The first i with req[i]=1 wins.
- "Others pending" means req has a bit set other than the current grant_idx.

State IDLE:
- If req != 0: search from last. Next edge: grant_idx=winner, grant_valid=1, hold_cnt=0, state=GRANT.
- Latency from req sampled to grant visible is 1 cycle.
- If req == 0: remain in IDLE.

State GRANT, evaluated in priority order:
1. Release (req[grant_idx]=0):
   - last=grant_idx.
   - If others are pending: search from grant_idx and load the new winner at the same edge, hold_cnt=0. No idle bubble.
   - Otherwise: grant_valid=0, state=IDLE.
2. Preempt (req[grant_idx]=1, hold_cnt==HOLD_MAX-1, others pending):
   - Same as release with others pending. The current requester loses the grant even though req is still high.
3. Otherwise: keep the grant. hold_cnt increments and saturates at HOLD_MAX-1.
   - A lone requester is never preempted.

Boundary rules:
- HOLD_MAX=1 rotates every cycle under contention.
- The preempted requester gets its next turn in round-robin order.
- req falling in the same cycle as the hold limit is treated as a release.
- hold_cnt is 8 bits wide.

Decomposition:
Shared include file (arb_defs.v):
- State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- Reset value of last, 2'd3.

Sub-module:
- Instantiate the existing decoder2x4 for the grant_idx -> grant decode, gated by grant_valid.
- Winner search is a local function, not a separate module.

Test Plan:
1. rst=1 for 2 cycles with req=1111 -> grant=0000, grant_valid=0, grant_idx=0 throughout.
2. req=0100 rises at cycle k -> grant=0100, grant_idx=2 at k+1. Drop req at cycle m -> grant=0000, grant_valid=0 at m+1.
3. HOLD_MAX=4, req=1111 held -> grant sequence is 0001 x4, 0010 x4, 0100 x4, 1000 x4, then repeats.
4. Handoff: req=0011, grant=0001; drop req[0] -> grant=0010 on the next edge, with no 0000 cycle in between.
5. req=0001 held 10 cycles, HOLD_MAX=4 -> grant=0001 for all cycles, no preemption.
6. Reset mid-operation:
   - Setup: grant=0100, pulse rst for 1 cycle -> grant=0000 at the next edge.
   - With req=1111 held, first grant after reset is 0001.
   - HOLD_MAX=1 with req=1010 -> grant alternates 0010, 1000 every cycle.

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
package rr_arbiter4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Requester 0 gets top priority after reset because the search starts after 3.
    localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/rr_arbiter4_decoder2x4.sv
// 2-to-4 one-hot decoder with enable; output is zero when disabled.
module decoder2x4
    import rr_arbiter4_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a bounded hold time under contention.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] hold_cnt;
    logic             others_c;
    logic             handoff_c;

    // First requester above start, wrapping; returns start when nothing else is set.
    function automatic logic [IDX_W-1:0] find_winner(input logic [NUM_REQ-1:0] r,
                                                     input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] idx;
        find_winner = start;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = start + IDX_W'(k);
            if (r[idx]) begin
                find_winner = idx;
            end
        end
    endfunction

    always_comb begin
        others_c  = |(req & ~(NUM_REQ'(1) << grant_idx));
        handoff_c = !req[grant_idx] || ((hold_cnt == HOLD_LAST) && others_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last        <= LAST_RST;
            hold_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant_idx   <= find_winner(req, last);
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Release or hold-limit preemption both hand off without an idle bubble.
                    if (handoff_c) begin
                        last     <= grant_idx;
                        hold_cnt <= '0;
                        if (others_c) begin
                            grant_idx <= find_winner(req, grant_idx);
                        end else begin
                            grant_valid <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder2x4 u_dec (
        .idx      (grant_idx),
        .en       (grant_valid),
        .onehot_c (grant)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (HOLD_MAX=4 and 1) against a tenure-based reference model.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] grant4, grant1;
    logic [1:0] idx4, idx1;
    logic       gv4, gv1;

    int total = 0;
    int bad   = 0;

    // Model: who owns the resource, for how many cycles, and who last released it.
    int hmax   [2] = '{4, 1};
    int m_owner[2];
    int m_last [2];
    int m_ten  [2];
    bit m_act  [2];

    always #5 clk = ~clk;

    rr_arbiter4 #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant4), .grant_idx(idx4), .grant_valid(gv4)
    );

    rr_arbiter4 #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant1), .grant_idx(idx1), .grant_valid(gv1)
    );

    function automatic int next_rr(logic [3:0] r, int start);
        for (int k = 1; k <= 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return start;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit others;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 0; m_owner[d] = 0; m_last[d] = 3; m_ten[d] = 0;
            end else if (!m_act[d]) begin
                if (req != 4'b0000) begin
                    m_owner[d] = next_rr(req, m_last[d]);
                    m_act[d]   = 1;
                    m_ten[d]   = 1;
                end
            end else begin
                others = 0;
                for (int i = 0; i < 4; i++) if (req[i] && i != m_owner[d]) others = 1;
                if (!req[m_owner[d]] || (m_ten[d] >= hmax[d] && others)) begin
                    m_last[d] = m_owner[d];
                    if (others) begin
                        m_owner[d] = next_rr(req, m_owner[d]);
                        m_ten[d]   = 1;
                    end else begin
                        m_act[d] = 0;
                    end
                end else begin
                    m_ten[d]++;
                end
            end
        end
    endtask

    function automatic logic [7:0] m_grant(int d);
        return m_act[d] ? 8'(1 << m_owner[d]) : 8'h0;
    endfunction

    // One clock: update model on the edge, then compare both instances just after it.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("grant_h4", 8'(grant4), m_grant(0));
        chk("idx_h4",   8'(idx4),   8'(m_owner[0]));
        chk("valid_h4", 8'(gv4),    8'(m_act[0]));
        chk("grant_h1", 8'(grant1), m_grant(1));
        chk("idx_h1",   8'(idx1),   8'(m_owner[1]));
        chk("valid_h1", 8'(gv1),    8'(m_act[1]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        // Reset held two cycles with all requests high
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("rst_grant", 8'(grant4), 8'h0);
            chk("rst_valid", 8'(gv4), 8'h0);
            chk("rst_idx",   8'(idx4), 8'h0);
        end
        rst = 1'b0;
        req = 4'b0000;
        cycle();
        chk("idle_grant", 8'(grant4), 8'h0);

        // Single request: one-cycle latency in, one-cycle latency out
        req = 4'b0100;
        cycle();
        chk("single_grant", 8'(grant4), 8'h4);
        chk("single_idx",   8'(idx4),   8'h2);
        req = 4'b0000;
        cycle();
        chk("drop_grant", 8'(grant4), 8'h0);
        chk("drop_valid", 8'(gv4),    8'h0);

        // Full contention from reset
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            cycle();
            chk("rot_h4", 8'(grant4), 8'(1 << ((c / 4) % 4)));
            chk("rot_h1", 8'(grant1), 8'(1 << (c % 4)));
        end

        // Release handoff with no idle bubble
        do_reset();
        req = 4'b0011;
        cycle();
        chk("ho_first", 8'(grant4), 8'h1);
        req = 4'b0010;
        cycle();
        chk("ho_next",  8'(grant4), 8'h2);
        chk("ho_valid", 8'(gv4),    8'h1);

        // Lone requester is never preempted
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("lone_h4", 8'(grant4), 8'h1);
            chk("lone_h1", 8'(grant1), 8'h1);
        end

        // Reset in the middle of a grant
        do_reset();
        req = 4'b0100;
        cycle();
        chk("mid_pre", 8'(grant4), 8'h4);
        rst = 1'b1;
        cycle();
        chk("mid_rst", 8'(grant4), 8'h0);
        rst = 1'b0;
        req = 4'b1111;
        cycle();
        chk("mid_after", 8'(grant4), 8'h1);

        // Two-way contention: HOLD_MAX=1 alternates every cycle
        do_reset();
        req = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("alt_h1", 8'(grant1), (c % 2 == 0) ? 8'h2 : 8'h8);
            chk("alt_h4", 8'(grant4), (c < 4) ? 8'h2 : 8'h8);
        end

        // Random sticky requests with occasional reset
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) req[i] = ~req[i];
            end
            rst = ($urandom_range(49) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
